noc_out_port_arb: RTL
=====================

Name: noc_out_port_arb

Overview:
- Per-output-port arbiter for the next-generation parametrised router.
- Selects among IN_PORTS input FIFOs (show-ahead noc_link_phy rx side) and forwards flits to one tx link through a one-entry output register.
- Adds wormhole burst locking, weighted round-robin favouring module ports, and a lock watchdog.
- One instance per router output port; all ports sit in the router clock domain.

Parameters:
- IN_PORTS, 5, number of requesting inputs (modules + links), >=2.
- MODULES_PER_ROUTER, 1, inputs [0..MODULES_PER_ROUTER-1] are module ports; the rest are router links.
- HDR_W, 36, flit header width.
- PAY_W, 64, flit payload width.
- BURST_BIT, 0, header bit index; 1 = more flits of this packet follow.
- MOD_WEIGHT, 2, consecutive packets a module port may win before the RR pointer advances (>=1).
- LOCK_TIMEOUT, 256, idle cycles allowed while locked; 0 disables the watchdog.

Ports:
- clk_i  in  1  router clock.
- reset_q_i  in  1  reset; asynchronous, active-low.
- req_i  in  IN_PORTS  head flit of input i is routed to this output; qualified by not-empty.
- flit_avail_q_i  in  IN_PORTS  1 = input FIFO i empty.
- header_i  in  HDR_W*IN_PORTS  head-flit headers, input i at [(i+1)*HDR_W-1:i*HDR_W].
- payload_i  in  PAY_W*IN_PORTS  head-flit payloads, same packing.
- rdreq_o  out  IN_PORTS  pop strobe; at most one bit set.
- header_o  out  HDR_W  registered header to tx link.
- payload_o  out  PAY_W  registered payload to tx link.
- wrreq_o  out  1  write strobe to tx link.
- stall_i  in  1  tx link full.
- lock_o  out  1  arbiter in LOCK state.
- grant_idx_o  out  $clog2(IN_PORTS)  index of current/last granted input.
- timeout_err_o  out  1  sticky watchdog error.

Behaviour:
- Reset values: all outputs 0; out_valid=0; state=IDLE; RR pointer=0; weight counter=0; watchdog=0.
- Eligible(i) = req_i[i] & ~flit_avail_q_i[i].
- Output register handshake:
  - wrreq_o = out_valid & ~stall_i; wrreq_o is never asserted while stall_i=1.
  - load = ~out_valid | wrreq_o.
  - On load with a grant, rdreq_o[g]=1 and header/payload of g are captured in the same cycle.
  - Latency: rdreq to wrreq is 1 cycle when unstalled; full throughput of 1 flit/cycle.
- IDLE:
  - Round-robin search starts at the RR pointer, wrapping IN_PORTS-1 -> 0.
  - On transfer, if header[BURST_BIT]=1, go to LOCK holding g; otherwise stay in IDLE.
  - Packet end (single flit, or last flit of a burst):
    - Module port: increment weight counter; if it reaches MOD_WEIGHT, pointer = g+1 and counter = 0; else pointer stays g.
    - Link port: pointer = g+1 and counter = 0.
- LOCK:
  - Only input g may transfer; req_i[g] is ignored, only ~flit_avail_q_i[g] is needed. Other inputs get no rdreq.
  - A flit with BURST_BIT=0 transferred -> IDLE, with the packet-end pointer update.
- Watchdog:
  - Counts cycles in LOCK with no transfer; cleared on every transfer.
  - Reaching LOCK_TIMEOUT: timeout_err_o=1 (sticky until reset), force IDLE, pointer = g+1.
- Simultaneous events:
  - A stalled full register with a waiting input gives no rdreq.
  - A register draining while a new flit loads in the same cycle is legal, so back-to-back transfers occur.
- No eligible input: no rdreq; out_valid drains normally.
- Async reset mid-packet: discards the register contents and the lock immediately; no wrreq is issued after reset assertion.
- grant_idx_o updates on each transfer; lock_o = (state==LOCK).

Test Plan:
- Inputs 1,2,3 each hold 3 single-flit packets, IN_PORTS=5, MOD_WEIGHT=2, stall_i=0 -> grant order 1,2,3,1,2,3,1,2,3; wrreq_o high 9 consecutive cycles, 1 cycle after the first rdreq.
- Input 0 (module) and input 4 continuously eligible, single flits -> grant pattern 0,0,4,0,0,4.
- Input 2 sends a 4-flit burst (BURST_BIT 1,1,1,0) while input 3 is eligible -> input 3 is not popped until the 4th flit of input 2 is transferred; lock_o high 3 cycles.
- stall_i=1 for 5 cycles with out_valid=1 -> wrreq_o=0 and rdreq_o=0 throughout; header_o stable; transfer resumes the cycle after stall_i falls.
- LOCK_TIMEOUT=8; input 1 bursts a first flit then goes empty -> after 8 idle cycles timeout_err_o=1 and lock_o=0; input 2 then granted.
- Assert reset_q_i in the middle of a burst -> all outputs 0 asynchronously; after release the first grant starts from pointer 0.

Source files
------------

// File: rtl/noc_out_port_arb.sv
// Per-output-port arbiter: wormhole burst locking, weighted round-robin
// favouring module ports, a one-entry output register and a lock watchdog.
module noc_out_port_arb #(
  parameter int IN_PORTS           = 5,
  parameter int MODULES_PER_ROUTER = 1,
  parameter int HDR_W              = 36,
  parameter int PAY_W              = 64,
  parameter int BURST_BIT          = 0,
  parameter int MOD_WEIGHT         = 2,
  parameter int LOCK_TIMEOUT       = 256
) (
  input  logic                        clk_i,
  input  logic                        reset_q_i,
  input  logic [IN_PORTS-1:0]         req_i,
  input  logic [IN_PORTS-1:0]         flit_avail_q_i,
  input  logic [HDR_W*IN_PORTS-1:0]   header_i,
  input  logic [PAY_W*IN_PORTS-1:0]   payload_i,
  output logic [IN_PORTS-1:0]         rdreq_o,
  output logic [HDR_W-1:0]            header_o,
  output logic [PAY_W-1:0]            payload_o,
  output logic                        wrreq_o,
  input  logic                        stall_i,
  output logic                        lock_o,
  output logic [$clog2(IN_PORTS)-1:0] grant_idx_o,
  output logic                        timeout_err_o
);

  localparam int IDX_W = $clog2(IN_PORTS);
  localparam int CNT_W = $clog2(MOD_WEIGHT + 1);
  localparam int WD_W  = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = (LOCK_TIMEOUT > 0) ? WD_W'(LOCK_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOD_WEIGHT - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;

  logic              out_valid_q;
  logic [HDR_W-1:0]  hdr_q;
  logic [PAY_W-1:0]  pay_q;
  logic [IDX_W-1:0]  grant_q;

  logic [HDR_W-1:0]  hdr_arr [IN_PORTS];
  logic [PAY_W-1:0]  pay_arr [IN_PORTS];
  logic [IN_PORTS-1:0] elig;
  logic [IN_PORTS-1:0] rdreq;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  rr_idx;
  logic              rr_found;
  logic [IDX_W-1:0]  sel;
  logic              can_go;
  logic              wr;
  logic              load;
  logic              xfer;
  logic              pkt_end;
  logic [HDR_W-1:0]  sel_hdr;
  logic [PAY_W-1:0]  sel_pay;
  logic              sel_burst;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(IN_PORTS - 1)) return '0;
    return idx + IDX_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < IN_PORTS; i++) begin
      hdr_arr[i] = header_i[i*HDR_W +: HDR_W];
      pay_arr[i] = payload_i[i*PAY_W +: PAY_W];
    end
  end

  assign elig = req_i & ~flit_avail_q_i;

  // Descending scan so the closest eligible input at or after the pointer wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = IN_PORTS - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_q) + k) % IN_PORTS);
      if (elig[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign wr        = out_valid_q & ~stall_i;
  assign load      = ~out_valid_q | wr;
  assign sel       = (state_q == LOCK) ? lock_idx_q : rr_idx;
  assign can_go    = (state_q == LOCK) ? ~flit_avail_q_i[lock_idx_q] : rr_found;
  assign xfer      = load & can_go;
  assign sel_hdr   = hdr_arr[sel];
  assign sel_pay   = pay_arr[sel];
  assign sel_burst = sel_hdr[BURST_BIT];
  assign rdreq     = xfer ? (IN_PORTS'(1) << sel) : '0;

  // Outputs are forced low combinationally while reset is asserted.
  assign rdreq_o       = rdreq & {IN_PORTS{reset_q_i}};
  assign wrreq_o       = wr;
  assign header_o      = hdr_q;
  assign payload_o     = pay_q;
  assign lock_o        = (state_q == LOCK);
  assign grant_idx_o   = grant_q;
  assign timeout_err_o = err_q;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    wcnt_d     = wcnt_q;
    wd_d       = wd_q;
    err_d      = err_q;
    pkt_end    = 1'b0;
    if (xfer) begin
      wd_d = '0;
      if (sel_burst) begin
        state_d    = LOCK;
        lock_idx_d = sel;
      end else begin
        state_d = IDLE;
        pkt_end = 1'b1;
      end
    end else if ((state_q == LOCK) && (LOCK_TIMEOUT > 0)) begin
      if (wd_q == WD_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
        ptr_d   = wrap_inc(lock_idx_q);
        wcnt_d  = '0;
        wd_d    = '0;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
    // Module ports keep the pointer until they have used up their weight.
    if (pkt_end) begin
      if (int'(sel) < MODULES_PER_ROUTER) begin
        if (wcnt_q == CNT_LAST) begin
          ptr_d  = wrap_inc(sel);
          wcnt_d = '0;
        end else begin
          ptr_d  = sel;
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end else begin
        ptr_d  = wrap_inc(sel);
        wcnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_q_i) begin
    if (!reset_q_i) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      ptr_q      <= '0;
      wcnt_q     <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
      wcnt_q     <= wcnt_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_q_i) begin
    if (!reset_q_i) begin
      out_valid_q <= 1'b0;
      hdr_q       <= '0;
      pay_q       <= '0;
      grant_q     <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      hdr_q       <= sel_hdr;
      pay_q       <= sel_pay;
      grant_q     <= sel;
    end else if (wr) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
